// File: rtl/alu_74382_pkg.sv
// Shared definitions for the slice-serial 74382-style ALU.
//   ORIG_OPERAND_W / SLICE_W : width of one 74382 slice (4 bits)
//   SELECT_W                 : width of the 74382 function select
//   OP_*                     : function select encoding of the original part
//   t_state                  : sequencer states of the serial top level
package alu_74382_pkg;

    localparam int ORIG_OPERAND_W = 4;
    localparam int SELECT_W       = 3;
    localparam int SLICE_W        = ORIG_OPERAND_W;

    localparam logic [SELECT_W-1:0] OP_CLEAR   = 3'd0;
    localparam logic [SELECT_W-1:0] OP_B_SUB_A = 3'd1;
    localparam logic [SELECT_W-1:0] OP_A_SUB_B = 3'd2;
    localparam logic [SELECT_W-1:0] OP_ADD     = 3'd3;
    localparam logic [SELECT_W-1:0] OP_XOR     = 3'd4;
    localparam logic [SELECT_W-1:0] OP_OR      = 3'd5;
    localparam logic [SELECT_W-1:0] OP_AND     = 3'd6;
    localparam logic [SELECT_W-1:0] OP_PRESET  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } t_state;

endpackage

// File: rtl/alu_74382_slice.sv
// One combinational 74382-style 4-bit ALU slice.
//   sel : function select (OP_*)
//   a,b : slice operands
//   ci  : Cn, carry into the slice
//   f   : function output
//   ovr : two's-complement overflow of the slice
//   co  : Cn+4, carry out of the slice
module alu_74382_slice
    import alu_74382_pkg::*;
(
    input  logic [SELECT_W-1:0] sel,
    input  logic [SLICE_W-1:0]  a,
    input  logic [SLICE_W-1:0]  b,
    input  logic                ci,
    output logic [SLICE_W-1:0]  f,
    output logic                ovr,
    output logic                co
);

    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W:0]   sum;
    logic [SLICE_W-1:0] low;   // top bit = carry into the slice MSB

    always_comb begin
        x = (sel == OP_B_SUB_A) ? ~a : a;
        y = (sel == OP_A_SUB_B) ? ~b : b;
        sum = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, ci};
        low = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, ci};

        f   = '0;
        ovr = 1'b0;
        co  = 1'b0;
        case (sel)
            OP_ADD, OP_A_SUB_B, OP_B_SUB_A: begin
                f   = sum[SLICE_W-1:0];
                co  = sum[SLICE_W];
                ovr = low[SLICE_W-1] ^ sum[SLICE_W];
            end
            // The part drives both carry-type outputs high on CLEAR.
            OP_CLEAR: begin
                ovr = 1'b1;
                co  = 1'b1;
            end
            // Logic functions and PRESET leave OVR and Cn+4 low.
            OP_XOR:    f = a ^ b;
            OP_OR:     f = a | b;
            OP_AND:    f = a & b;
            OP_PRESET: f = '1;
            default:   f = '0;
        endcase
    end

endmodule

// File: rtl/alu_74382_serial.sv
// Slice-serial WIDTH-bit ALU built from 74382-style 4-bit slices.
// Evaluates SLICES_PER_CYCLE slices per clock, carry rippling between
// steps through carry_reg; result and flags are presented with a
// valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   sel, port_a, port_b  : function select and operands
//   carry_in             : Cn into the least significant slice
//   out_valid / out_ready: result handshake (held in DONE)
//   result               : F output
//   carry_out, overflow  : Cn+4 and OVR of the most significant slice
//   zero                 : result == 0
//   busy                 : op in flight or result waiting
module alu_74382_serial
    import alu_74382_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SELECT_W-1:0] sel,
    input  logic [WIDTH-1:0]    port_a,
    input  logic [WIDTH-1:0]    port_b,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                carry_out,
    output logic                overflow,
    output logic                zero,
    output logic                busy
);

    localparam int SPC        = (SLICES_PER_CYCLE < 1) ? 1 : SLICES_PER_CYCLE;
    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int NUM_STEPS  = (NUM_SLICES < SPC) ? 1 : NUM_SLICES / SPC;
    localparam int GRP_W      = SPC * SLICE_W;
    localparam int STEP_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    if ((WIDTH < SLICE_W) || (WIDTH % SLICE_W != 0) || (SLICES_PER_CYCLE < 1) ||
        (NUM_SLICES % SPC != 0)) begin : g_bad_params
        $error("alu_74382_serial: WIDTH must be a multiple of 4 and SLICES_PER_CYCLE must divide WIDTH/4");
    end

    t_state                state, state_nxt;
    logic [STEP_W-1:0]     step;
    logic [SELECT_W-1:0]   op_sel;
    logic [WIDTH-1:0]      a_reg, b_reg, result_reg, result_nxt;
    logic                  carry_reg, carry_out_reg, overflow_reg, zero_reg;

    logic [IDX_W-1:0]              base;
    logic [SPC:0]                  chain;
    logic [SPC-1:0][SLICE_W-1:0]   grp_f;
    logic [SPC-1:0]                grp_ovr;
    logic                          unused_ovr;

    assign base       = IDX_W'(int'(step) * GRP_W);
    assign chain[0]   = carry_reg;
    // Only the top slice's OVR matters; the rest are intentionally dropped.
    assign unused_ovr = ^grp_ovr;

    for (genvar gi = 0; gi < SPC; gi++) begin : g_slice
        alu_74382_slice u_slice (
            .sel (op_sel),
            .a   (a_reg[base + IDX_W'(gi * SLICE_W) +: SLICE_W]),
            .b   (b_reg[base + IDX_W'(gi * SLICE_W) +: SLICE_W]),
            .ci  (chain[gi]),
            .f   (grp_f[gi]),
            .ovr (grp_ovr[gi]),
            .co  (chain[gi+1])
        );
    end

    // Result word with this step's nibbles merged in; also feeds zero detect
    // on the final step so the flag is ready together with out_valid.
    always_comb begin
        result_nxt = result_reg;
        result_nxt[base +: GRP_W] = grp_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (step == LAST_STEP) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step          <= '0;
            op_sel        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_sel    <= sel;
                        a_reg     <= port_a;
                        b_reg     <= port_b;
                        carry_reg <= carry_in;
                        step      <= '0;
                    end
                end
                RUN: begin
                    result_reg <= result_nxt;
                    carry_reg  <= chain[SPC];
                    step       <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        carry_out_reg <= chain[SPC];
                        overflow_reg  <= grp_ovr[SPC-1];
                        zero_reg      <= (result_nxt == '0);
                        step          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_alu_74382_serial.sv
module tb_alu_74382_serial;
    import alu_74382_pkg::*;

    localparam int ND = 3;  // instances with SLICES_PER_CYCLE = 1, 2, 4

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        carry_in = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [15:0] port_a = 16'h0;
    logic [15:0] port_b = 16'h0;

    logic        in_ready [ND];
    logic        out_valid[ND];
    logic        carry_out[ND];
    logic        overflow [ND];
    logic        zero     [ND];
    logic        busy     [ND];
    logic [15:0] result   [ND];

    int          got_lat[ND];
    logic        got_rdy[ND];
    logic [15:0] got_res[ND];
    logic        got_co [ND];
    logic        got_ov [ND];
    logic        got_z  [ND];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_74382_serial #(.WIDTH(16), .SLICES_PER_CYCLE(1)) u_spc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .sel(sel), .port_a(port_a), .port_b(port_b), .carry_in(carry_in),
        .out_valid(out_valid[0]), .out_ready(out_ready), .result(result[0]),
        .carry_out(carry_out[0]), .overflow(overflow[0]), .zero(zero[0]), .busy(busy[0]));

    alu_74382_serial #(.WIDTH(16), .SLICES_PER_CYCLE(2)) u_spc2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .sel(sel), .port_a(port_a), .port_b(port_b), .carry_in(carry_in),
        .out_valid(out_valid[1]), .out_ready(out_ready), .result(result[1]),
        .carry_out(carry_out[1]), .overflow(overflow[1]), .zero(zero[1]), .busy(busy[1]));

    alu_74382_serial #(.WIDTH(16), .SLICES_PER_CYCLE(4)) u_spc4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .sel(sel), .port_a(port_a), .port_b(port_b), .carry_in(carry_in),
        .out_valid(out_valid[2]), .out_ready(out_ready), .result(result[2]),
        .carry_out(carry_out[2]), .overflow(overflow[2]), .zero(zero[2]), .busy(busy[2]));

    // Word-level reference: {result, carry_out, overflow, zero}.
    function automatic logic [18:0] ref_alu(input logic [2:0] s, input logic [15:0] a,
                                            input logic [15:0] b, input logic ci);
        logic [16:0] sum;
        logic [15:0] x, y, f;
        logic        co, ov;
        x = a; y = b; f = 16'h0; co = 1'b0; ov = 1'b0;
        case (s)
            3'd0: begin co = 1'b1; ov = 1'b1; end
            3'd1, 3'd2, 3'd3: begin
                if (s == 3'd1) x = ~a;
                if (s == 3'd2) y = ~b;
                sum = {1'b0, x} + {1'b0, y} + {16'h0, ci};
                f   = sum[15:0];
                co  = sum[16];
                ov  = (x[15] == y[15]) && (f[15] != x[15]);
            end
            3'd4: f = a ^ b;
            3'd5: f = a | b;
            3'd6: f = a & b;
            default: f = 16'hFFFF;
        endcase
        return {f, co, ov, (f == 16'h0)};
    endfunction

    // Issue one op to all instances with out_ready high, then watch 10 cycles
    // recording each instance's first out_valid cycle and outputs.
    task automatic run_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                          input logic ci);
        for (int d = 0; d < ND; d++) begin
            got_lat[d] = -1;
            got_rdy[d] = in_ready[d];
            got_res[d] = 'x; got_co[d] = 1'bx; got_ov[d] = 1'bx; got_z[d] = 1'bx;
        end
        sel = s; port_a = a; port_b = b; carry_in = ci; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble ports: an in-flight op must not see them
        sel = 3'($urandom); port_a = 16'($urandom); port_b = 16'($urandom);
        carry_in = 1'($urandom);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                if (got_lat[d] < 0 && out_valid[d]) begin
                    got_lat[d] = k;
                    got_res[d] = result[d]; got_co[d] = carry_out[d];
                    got_ov[d]  = overflow[d]; got_z[d] = zero[d];
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
                result[d] !== 16'h0 || carry_out[d] !== 1'b0 || overflow[d] !== 1'b0 ||
                zero[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset[spc%0d] rdy=%b vld=%b busy=%b res=%h co=%b ov=%b z=%b, required 1 0 0 0000 0 0 0",
                         1 << d, in_ready[d], out_valid[d], busy[d], result[d], carry_out[d],
                         overflow[d], zero[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  s;
        logic [15:0] a, b;
        logic        ci;
        logic [15:0] r;
        logic        co, ov, z;
    } vec_t;

    task automatic test_directed();
        vec_t tv[6];
        tv[0] = '{OP_ADD,     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tv[1] = '{OP_ADD,     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tv[2] = '{OP_A_SUB_B, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tv[3] = '{OP_B_SUB_A, 16'h0003, 16'h0010, 1'b1, 16'h000D, 1'b1, 1'b0, 1'b0};
        tv[4] = '{OP_CLEAR,   16'h1234, 16'hABCD, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tv[5] = '{OP_PRESET,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].s, tv[i].a, tv[i].b, tv[i].ci);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (got_rdy[d] !== 1'b1 || got_lat[d] != (4 >> d)) begin
                    failures++;
                    $display("FAIL dir%0d[spc%0d] latency got=%0d rdy=%b, required %0d rdy=1",
                             i, 1 << d, got_lat[d], got_rdy[d], 4 >> d);
                end
                checks++;
                if (got_res[d] !== tv[i].r || got_co[d] !== tv[i].co ||
                    got_ov[d] !== tv[i].ov || got_z[d] !== tv[i].z) begin
                    failures++;
                    $display("FAIL dir%0d[spc%0d] res/co/ov/z got=%h %b %b %b, required %h %b %b %b",
                             i, 1 << d, got_res[d], got_co[d], got_ov[d], got_z[d],
                             tv[i].r, tv[i].co, tv[i].ov, tv[i].z);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int waited;
        out_ready = 1'b0;
        sel = OP_ADD; port_a = 16'h1234; port_b = 16'h4321; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        // pulse during RUN of the slowest instance; must be ignored
        sel = OP_PRESET; port_a = 16'hDEAD; port_b = 16'hBEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid[0] && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || result[d] !== 16'h5555 ||
                    carry_out[d] !== 1'b0 || overflow[d] !== 1'b0 || zero[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL hold%0d[spc%0d] vld=%b rdy=%b res=%h co=%b ov=%b z=%b, required 1 0 5555 0 0 0",
                             c, 1 << d, out_valid[d], in_ready[d], result[d], carry_out[d],
                             overflow[d], zero[d]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL release[spc%0d] vld=%b rdy=%b busy=%b, required 0 1 0",
                         1 << d, out_valid[d], in_ready[d], busy[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] exp;
        int          seen;
        out_ready = 1'b1;
        sel = OP_ADD; port_a = 16'h1111; port_b = 16'h2222; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 ||
                result[d] !== 16'h0 || carry_out[d] !== 1'b0 || overflow[d] !== 1'b0 ||
                zero[d] !== 1'b0) begin
                failures++;
                $display("FAIL midrst[spc%0d] busy=%b rdy=%b vld=%b res=%h co=%b ov=%b z=%b, required 0 1 0 0000 0 0 0",
                         1 << d, busy[d], in_ready[d], out_valid[d], result[d], carry_out[d],
                         overflow[d], zero[d]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) if (out_valid[d]) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrst_no_valid out_valid seen=%0d, required 0", seen);
        end
        exp = ref_alu(OP_ADD, 16'h0F0F, 16'h00F1, 1'b1);
        run_op(OP_ADD, 16'h0F0F, 16'h00F1, 1'b1);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (got_lat[d] != (4 >> d) || got_res[d] !== 16'h1001 ||
                {got_res[d], got_co[d], got_ov[d], got_z[d]} !== exp) begin
                failures++;
                $display("FAIL after_rst[spc%0d] lat=%0d res=%h co=%b ov=%b z=%b, required lat=%0d %h",
                         1 << d, got_lat[d], got_res[d], got_co[d], got_ov[d], got_z[d],
                         4 >> d, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  s;
        logic [15:0] a, b;
        logic        ci;
        logic [18:0] exp;
        for (int i = 0; i < 1000; i++) begin
            s  = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            ci = 1'($urandom);
            exp = ref_alu(s, a, b, ci);
            run_op(s, a, b, ci);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (got_lat[d] != (4 >> d) ||
                    {got_res[d], got_co[d], got_ov[d], got_z[d]} !== exp) begin
                    failures++;
                    $display("FAIL rand%0d[spc%0d] sel=%0d a=%h b=%h ci=%b got lat=%0d res=%h co=%b ov=%b z=%b, required lat=%0d res=%h co=%b ov=%b z=%b",
                             i, 1 << d, s, a, b, ci, got_lat[d], got_res[d], got_co[d],
                             got_ov[d], got_z[d], 4 >> d, exp[18:3], exp[2], exp[1], exp[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
